// File: rtl/block_merge.sv
`default_nettype none
// ============================================================================
// Module      : block_merge
// Description : Merges two valid/ready input streams into one registered
//               output stream. Each input is buffered in its own FIFO;
//               arbitration is round-robin or fixed priority (in1 first).
//               out2 tags every output word with its source channel.
// Revision    : 1.0 - initial release
// ============================================================================
module block_merge #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int RR_MODE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in1,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in2,
    input  logic             in2_valid,
    output logic             in2_ready,
    output logic [WIDTH-1:0] out1,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic             out2
);

    localparam int AW = $clog2(DEPTH);

    // Count value meaning "full"; count spans 0..DEPTH so it needs AW+1 bits.
    localparam logic [AW:0]   c_FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] c_PTR_ONE = AW'(1);

    // Channel index 0 = in1, 1 = in2 throughout.
    logic [1:0]            w_in_valid;
    logic [1:0][WIDTH-1:0] w_in_data;
    logic [1:0]            w_ready;
    logic [1:0]            w_wr;
    logic [1:0]            w_rd;
    logic [1:0]            w_nonempty;
    logic [1:0][WIDTH-1:0] w_head;

    logic                  w_can_load;
    logic                  w_load;
    logic                  w_grant;

    // Arbiter memory: channel granted most recently (1 = in2).
    logic                  r_last;

    logic [WIDTH-1:0]      r_out_data;
    logic                  r_out_tag;
    logic                  r_out_valid;

    assign w_in_valid   = {in2_valid, in1_valid};
    assign w_in_data[0] = in1;
    assign w_in_data[1] = in2;

    assign in1_ready = w_ready[0];
    assign in2_ready = w_ready[1];

    // ------------------------------------------------------------------------
    // Per-channel input FIFOs
    // ------------------------------------------------------------------------
    generate
        for (genvar g = 0; g < 2; g++) begin : g_fifo
            logic [WIDTH-1:0] r_mem [DEPTH];
            logic [AW-1:0]    r_wptr;
            logic [AW-1:0]    r_rptr;
            logic [AW:0]      r_count;

            // Ready depends only on occupancy: a slot freed by a read in the
            // same cycle is not reusable until the following cycle.
            assign w_ready[g]    = !reset && (r_count != c_FULL);
            assign w_wr[g]       = w_in_valid[g] && w_ready[g];
            assign w_nonempty[g] = (r_count != '0);
            assign w_head[g]     = r_mem[r_rptr];

            // Storage array: data only, never needs clearing.
            always_ff @(posedge clk) begin
                if (w_wr[g]) begin
                    r_mem[r_wptr] <= w_in_data[g];
                end
            end

            // Pointers wrap naturally modulo DEPTH; count tracks occupancy.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_count <= '0;
                end else begin
                    if (w_wr[g]) begin
                        r_wptr <= r_wptr + c_PTR_ONE;
                    end
                    if (w_rd[g]) begin
                        r_rptr <= r_rptr + c_PTR_ONE;
                    end
                    case ({w_wr[g], w_rd[g]})
                        2'b10:   r_count <= r_count + c_CNT_ONE;
                        2'b01:   r_count <= r_count - c_CNT_ONE;
                        default: r_count <= r_count;
                    endcase
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Arbitration and output stage
    // ------------------------------------------------------------------------
    assign w_can_load = !r_out_valid || out1_ready;
    assign w_load     = w_can_load && (|w_nonempty);
    assign w_rd[0]    = w_load && !w_grant;
    assign w_rd[1]    = w_load &&  w_grant;

    // Grant selection: a lone non-empty FIFO always wins; on a tie either
    // alternate against the last grant or favour in1.
    always_comb begin
        w_grant = 1'b0;
        if (w_nonempty == 2'b10) begin
            w_grant = 1'b1;
        end else if (w_nonempty == 2'b11) begin
            if (RR_MODE != 0) begin
                w_grant = !r_last;
            end else begin
                w_grant = 1'b0;
            end
        end
    end

    // Last-grant register; reset to in2 so in1 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (w_load) begin
            r_last <= w_grant;
        end
    end

    // Output register: load from granted head, else retire the accepted word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_tag   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_data  <= w_head[w_grant];
            r_out_tag   <= w_grant;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out1_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out1       = r_out_data;
    assign out2       = r_out_tag;
    assign out1_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_block_merge.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_merge
// Description : Self-checking bench for block_merge. Two instances run side
//               by side: index 0 round-robin, index 1 fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_merge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       out1_ready;
    logic [7:0] din    [2][2];   // [dut][channel]
    logic       dv     [2][2];
    logic       rdy    [2][2];
    logic [7:0] dout   [2];
    logic       dvalid [2];
    logic       dtag   [2];

    int checks = 0;
    int errors = 0;

    // Reference state: per dut/channel FIFO of accepted words (index d*2+c).
    logic [7:0] sbq    [4][$];
    logic [8:0] outlog [2][$];
    bit         acc    [2][2];
    bit         hold   [2];
    logic [31:0] hold_val [2];
    int         rxcnt  [2][2];
    int         sent   [2][2];

    block_merge #(.WIDTH(8), .DEPTH(4), .RR_MODE(1)) u_rr (
        .clk(clk), .reset(reset),
        .in1(din[0][0]), .in1_valid(dv[0][0]), .in1_ready(rdy[0][0]),
        .in2(din[0][1]), .in2_valid(dv[0][1]), .in2_ready(rdy[0][1]),
        .out1(dout[0]), .out1_valid(dvalid[0]), .out1_ready(out1_ready),
        .out2(dtag[0])
    );

    block_merge #(.WIDTH(8), .DEPTH(4), .RR_MODE(0)) u_fp (
        .clk(clk), .reset(reset),
        .in1(din[1][0]), .in1_valid(dv[1][0]), .in1_ready(rdy[1][0]),
        .in2(din[1][1]), .in2_valid(dv[1][1]), .in2_ready(rdy[1][1]),
        .out1(dout[1]), .out1_valid(dvalid[1]), .out1_ready(out1_ready),
        .out2(dtag[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observes handshakes about to happen at the next rising edge.
    task automatic monitor();
        logic [7:0] e;
        int qi;
        for (int d = 0; d < 2; d++) begin
            if (hold[d]) begin
                check($sformatf("stable%0d", d),
                      {23'b0, dvalid[d], dtag[d], dout[d]}, hold_val[d]);
            end
            for (int c = 0; c < 2; c++) begin
                acc[d][c] = !reset && dv[d][c] && rdy[d][c];
            end
            if (reset) begin
                sbq[d*2].delete();
                sbq[d*2+1].delete();
                hold[d] = 1'b0;
            end else begin
                if (dvalid[d] && out1_ready) begin
                    qi = d * 2 + int'(dtag[d]);
                    outlog[d].push_back({dtag[d], dout[d]});
                    check($sformatf("avail%0d", d), 32'(sbq[qi].size() != 0), 32'd1);
                    if (sbq[qi].size() != 0) begin
                        e = sbq[qi].pop_front();
                        check($sformatf("data%0d_ch%0d", d, dtag[d]), 32'(dout[d]), 32'(e));
                    end
                    rxcnt[d][dtag[d]]++;
                end
                for (int c = 0; c < 2; c++) begin
                    if (acc[d][c]) sbq[d*2+c].push_back(din[d][c]);
                end
                hold[d]     = dvalid[d] && !out1_ready;
                hold_val[d] = {23'b0, dvalid[d], dtag[d], dout[d]};
            end
        end
    endtask

    // Inputs are set at the falling edge; observe, then advance one cycle.
    task automatic cyc();
        #1;
        monitor();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        out1_ready = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++) begin
                dv[d][c] = 1'b0;
                din[d][c] = 8'h00;
            end
        cyc();
        cyc();
        reset = 1'b0;
        outlog[0].delete();
        outlog[1].delete();
    endtask

    // Offer one word on channel c to both instances until each accepts it.
    task automatic send_both(input int c, input logic [7:0] data);
        for (int d = 0; d < 2; d++) begin
            din[d][c] = data;
            dv[d][c]  = 1'b1;
        end
        for (int t = 0; t < 20 && (dv[0][c] || dv[1][c]); t++) begin
            cyc();
            for (int d = 0; d < 2; d++) if (acc[d][c]) dv[d][c] = 1'b0;
        end
        check($sformatf("send_ch%0d", c), 32'(dv[0][c] || dv[1][c]), 32'd0);
        dv[0][c] = 1'b0;
        dv[1][c] = 1'b0;
    endtask

    task automatic wait_outputs(input int n, input int bound);
        for (int t = 0; t < bound && (outlog[0].size() < n || outlog[1].size() < n); t++)
            cyc();
    endtask

    // Expected merge order when both channels are preloaded, from the
    // arbitration rules: alternate on ties (starting with in1) or in1 first.
    task automatic merge_model(input bit rr, output logic [8:0] exp_q[$]);
        logic [7:0] q1[$];
        logic [7:0] q2[$];
        int last;
        q1 = '{8'd10, 8'd11, 8'd12};
        q2 = '{8'd20, 8'd21, 8'd22};
        last = 2;
        exp_q.delete();
        while (q1.size() + q2.size() > 0) begin
            int pick;
            if (q1.size() == 0)       pick = 2;
            else if (q2.size() == 0)  pick = 1;
            else if (rr)              pick = (last == 1) ? 2 : 1;
            else                      pick = 1;
            last = pick;
            if (pick == 1) exp_q.push_back({1'b0, q1.pop_front()});
            else           exp_q.push_back({1'b1, q2.pop_front()});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] exp_q[$];
        int cy;
        bit busy;

        reset = 1'b1;
        out1_ready = 1'b0;
        for (int d = 0; d < 2; d++) begin
            hold[d] = 1'b0;
            for (int c = 0; c < 2; c++) begin
                dv[d][c] = 1'b0; din[d][c] = 8'h00; acc[d][c] = 1'b0;
                rxcnt[d][c] = 0; sent[d][c] = 0;
            end
        end
        @(negedge clk);

        // ---- Reset state ----
        cyc();
        cyc();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_valid%0d", d), 32'(dvalid[d]), 32'd0);
            check($sformatf("rst_out1_%0d", d), 32'(dout[d]), 32'd0);
            check($sformatf("rst_out2_%0d", d), 32'(dtag[d]), 32'd0);
            check($sformatf("rst_rdy1_%0d", d), 32'(rdy[d][0]), 32'd0);
            check($sformatf("rst_rdy2_%0d", d), 32'(rdy[d][1]), 32'd0);
        end
        reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rdy1_after_rst%0d", d), 32'(rdy[d][0]), 32'd1);
            check($sformatf("rdy2_after_rst%0d", d), 32'(rdy[d][1]), 32'd1);
        end
        @(negedge clk);

        // ---- Single word, 2-cycle latency, valid for exactly one cycle ----
        out1_ready = 1'b1;
        send_both(0, 8'hA5);
        for (int d = 0; d < 2; d++) check($sformatf("lat_k_%0d", d), 32'(dvalid[d]), 32'd0);
        cyc();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("lat_k1_%0d", d), 32'(dvalid[d]), 32'd1);
            check($sformatf("single_data%0d", d), 32'(dout[d]), 32'hA5);
            check($sformatf("single_tag%0d", d), 32'(dtag[d]), 32'd0);
        end
        cyc();
        for (int d = 0; d < 2; d++) check($sformatf("lat_k2_%0d", d), 32'(dvalid[d]), 32'd0);

        // ---- Fill / full on channel 2 ----
        do_reset();
        out1_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_both(1, 8'(i));
        for (int d = 0; d < 2; d++) begin
            din[d][1] = 8'd6;
            dv[d][1]  = 1'b1;
        end
        for (int t = 0; t < 3; t++) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("full_rdy%0d", d), 32'(rdy[d][1]), 32'd0);
                check($sformatf("full_hold%0d", d), {23'b0, dvalid[d], dtag[d], dout[d]}, 32'h301);
            end
            cyc();
        end
        out1_ready = 1'b1;
        for (int t = 0; t < 20 && (outlog[0].size() < 6 || outlog[1].size() < 6); t++) begin
            for (int d = 0; d < 2; d++)
                if (outlog[d].size() < 6) check($sformatf("nogap%0d", d), 32'(dvalid[d]), 32'd1);
            cyc();
            for (int d = 0; d < 2; d++) if (acc[d][1]) dv[d][1] = 1'b0;
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("fill_count%0d", d), 32'(outlog[d].size()), 32'd6);
            for (int i = 0; i < outlog[d].size() && i < 6; i++)
                check($sformatf("fill_seq%0d_%0d", d, i), 32'(outlog[d][i]), 32'(9'h100 + i + 1));
        end

        // ---- Arbitration: round-robin (dut 0) and fixed priority (dut 1) ----
        do_reset();
        out1_ready = 1'b0;
        send_both(0, 8'd10); send_both(0, 8'd11); send_both(0, 8'd12);
        send_both(1, 8'd20); send_both(1, 8'd21); send_both(1, 8'd22);
        out1_ready = 1'b1;
        wait_outputs(6, 30);
        for (int d = 0; d < 2; d++) begin
            merge_model(d == 0, exp_q);
            check($sformatf("arb_count%0d", d), 32'(outlog[d].size()), 32'd6);
            for (int i = 0; i < 6 && i < outlog[d].size(); i++)
                check($sformatf("arb_seq%0d_%0d", d, i), 32'(outlog[d][i]), 32'(exp_q[i]));
        end

        // ---- Random traffic with random backpressure ----
        do_reset();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++) begin
                rxcnt[d][c] = 0; sent[d][c] = 0; acc[d][c] = 1'b0;
            end
        cy = 0;
        while (cy < 20000) begin
            busy = 1'b0;
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < 2; c++) begin
                    if (dv[d][c] && !acc[d][c]) begin
                        busy = 1'b1;
                    end else if (sent[d][c] < 1000 && $urandom_range(0, 1) == 1) begin
                        dv[d][c]  = 1'b1;
                        din[d][c] = 8'($urandom);
                        sent[d][c]++;
                        busy = 1'b1;
                    end else begin
                        dv[d][c] = 1'b0;
                        if (sent[d][c] < 1000) busy = 1'b1;
                    end
                end
            if (!busy) break;
            out1_ready = ($urandom_range(0, 1) == 1);
            cyc();
            cy++;
        end
        check("rand_timeout", 32'(cy < 20000), 32'd1);
        out1_ready = 1'b1;
        for (int t = 0; t < 100; t++) begin
            if (sbq[0].size() == 0 && sbq[1].size() == 0 && sbq[2].size() == 0 &&
                sbq[3].size() == 0 && !dvalid[0] && !dvalid[1]) break;
            cyc();
        end
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 2; c++) begin
                check($sformatf("rand_sent%0d_%0d", d, c), 32'(sent[d][c]), 32'd1000);
                check($sformatf("rand_rx%0d_%0d", d, c), 32'(rxcnt[d][c]), 32'd1000);
                check($sformatf("rand_left%0d_%0d", d, c), 32'(sbq[d*2+c].size()), 32'd0);
            end
            check($sformatf("rand_idle%0d", d), 32'(dvalid[d]), 32'd0);
        end

        // ---- Reset mid-stream ----
        do_reset();
        out1_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_both(0, 8'(8'h30 + i));
        for (int i = 0; i < 3; i++) send_both(1, 8'(8'h40 + i));
        for (int d = 0; d < 2; d++) check($sformatf("pre_rst_valid%0d", d), 32'(dvalid[d]), 32'd1);
        reset = 1'b1;
        out1_ready = 1'b1;
        #1;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++)
                check($sformatf("mid_rst_rdy%0d_%0d", d, c), 32'(rdy[d][c]), 32'd0);
        cyc();
        reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("post_rst_valid%0d", d), 32'(dvalid[d]), 32'd0);
            for (int c = 0; c < 2; c++)
                check($sformatf("post_rst_rdy%0d_%0d", d, c), 32'(rdy[d][c]), 32'd1);
        end
        @(negedge clk);
        for (int t = 0; t < 10; t++) begin
            cyc();
            for (int d = 0; d < 2; d++) check($sformatf("no_stale%0d", d), 32'(dvalid[d]), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/block_merge.md
Name: block_merge

Overview:
- Parametrised successor to the two-input/two-output block: merges two independent valid/ready input streams of WIDTH bits into one output stream.
- Each input is buffered in its own DEPTH-entry FIFO.
- Selectable arbitration: round-robin or fixed priority.
- out2 tags every output word with its source channel.
- Sits between two producers and a single shared downstream consumer.

Parameters:
WIDTH, 8, data width of in1/in2/out1
DEPTH, 4, entries per input FIFO; power of 2, >= 2
RR_MODE, 1, 1 = round-robin arbitration; 0 = fixed priority, in1 always wins

Ports:
clk  input  1  main clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in1  input  WIDTH  channel 1 data
in1_valid  input  1  channel 1 data valid
in1_ready  output  1  channel 1 FIFO can accept
in2  input  WIDTH  channel 2 data
in2_valid  input  1  channel 2 data valid
in2_ready  output  1  channel 2 FIFO can accept
out1  output  WIDTH  merged output data (registered)
out1_valid  output  1  out1/out2 hold a valid word
out1_ready  input  1  downstream accepts the word
out2  output  1  source tag of out1: 0 = in1, 1 = in2

Behaviour:
- Clocking/reset: one clock (clk); reset is synchronous and active-high.
- Values in reset:
  - FIFOs empty, pointers 0.
  - out1 = 0, out1_valid = 0, out2 = 0.
  - RR "last granted" = channel 2, so in1 wins the first tie.
  - in1_ready = in2_ready = 0 while reset is high.
- Reset mid-operation: all buffered and output-staged words are discarded, with no partial output; state returns to the reset state on the next edge.
- Input acceptance:
  - inN_ready = !fifoN_full; it never depends on out1_ready.
  - A word is written on any edge where inN_valid && inN_ready.
  - Data is sampled only on that edge.
- FIFO:
  - Per-channel count spans 0..DEPTH; read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Simultaneous write and read in one cycle leaves the count unchanged.
  - Full: no write is possible because ready is low, including the cycle a read frees a slot; ready rises the cycle after.
- Output stage:
  - Loads on an edge where (!out1_valid || out1_ready) and at least one FIFO is non-empty.
  - The load pops the granted FIFO and sets out1/out2 from the FIFO head and grant, with out1_valid = 1.
  - If nothing is loaded and out1_ready && out1_valid, out1_valid clears; out1/out2 hold their last values.
  - While out1_valid && !out1_ready, out1/out2/out1_valid are stable.
- Arbitration, evaluated each edge where the stage can load:
  - Only one FIFO non-empty: grant it.
  - Both non-empty, RR_MODE = 1: grant the channel not granted last; update "last granted" on every grant.
  - Both non-empty, RR_MODE = 0: grant in1; channel 2 can starve.
- Latency and throughput:
  - A word accepted at edge k, into an empty FIFO with a free output stage, shows out1_valid = 1 after edge k+1 (2 cycles).
  - Sustained throughput is 1 word/cycle aggregate when out1_ready = 1.
- Ordering: per-channel order is preserved; there is no reordering within a channel.
- No data loss and no duplication under any backpressure pattern.

Test Plan:
1. Reset then single word:
   - Stimulus: in1 = 8'hA5 with in1_valid for 1 cycle, out1_ready = 1.
   - Response: out1 = A5, out2 = 0, out1_valid high exactly 1 cycle, 2 cycles after acceptance.
2. Fill/full:
   - Stimulus: out1_ready = 0; drive in2 valid with 1,2,3,4,5,6 (DEPTH = 4).
   - Response: 1 lands in the output stage; 2–5 fill FIFO2; in2_ready = 0 while 6 is offered.
   - Then set out1_ready = 1: out1 = 1,2,3,4,5,6 in order, all with out2 = 1, no gaps after the first.
3. Round-robin:
   - Stimulus: RR_MODE = 1; preload in1 = 10,11,12 and in2 = 20,21,22; then out1_ready = 1.
   - Response: output sequence 10,20,11,21,12,22 with out2 = 0,1,0,1,0,1.
4. Fixed priority:
   - Stimulus: RR_MODE = 0, same preload as scenario 3.
   - Response: 10,11,12,20,21,22.
5. Random backpressure:
   - Stimulus: 1000 random words per channel, random valid and random out1_ready (50%).
   - Response: scoreboard shows per-channel order intact, no loss/duplication, and out1/out2 stable whenever out1_valid && !out1_ready.
6. Reset mid-stream:
   - Stimulus: assert reset for 1 cycle with both FIFOs holding 3 words and out1_valid = 1.
   - Response: the next cycle out1_valid = 0, readies low during reset then high, and no stale word ever appears afterwards.
